hi_sim_seq: RTL
===============

Name: hi_sim_seq

Overview:
- Response sequencer for the 13.56 MHz tag-simulation front end.
- Watches the reader-field comparator for the end of a reader frame and waits a programmed frame-delay time (FDT).
- Then drives mod_type and a Manchester-coded bit stream from a small ARM-loaded response buffer into the simulation modulator, and returns the front end to listen mode.
- Replaces ARM software timing of the tag reply, giving cycle-exact FDT.

Parameters:
- BIT_CYCLES, 128: carrier cycles per response bit (fc/128 = 106 kbit/s); must be even.
- PAUSE_MIN, 8: minimum low run on rx_field, in cycles, that counts as a reader pause.
- MIN_FDT, 256: lower clamp applied to fdt_cycles.
- MOD_TX, 3'b100: mod_type value driven while transmitting.

Ports:
- ck_1356meg  in  1  13.56 MHz carrier clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that arms the sequencer.
- abort  in  1  returns to IDLE from any state.
- fdt_cycles  in  12  frame delay in carrier cycles, sampled on start.
- nbits  in  8  number of response data bits, sampled on start.
- wr_en  in  1  response-buffer byte write strobe.
- wr_addr  in  5  buffer byte address (32 x 8 bits).
- wr_data  in  8  buffer byte data.
- rx_field  in  1  after-hysteresis comparator: 1 = field present, 0 = reader pause.
- mod_type  out  3  to the modulator: 3'b000 listen, MOD_TX during transmit.
- mod_dout  out  1  Manchester-coded bit to the modulator.
- busy  out  1  high in every state except IDLE.
- tx_active  out  1  high in TX.
- done  out  1  one-cycle pulse when transmission completes.

Behaviour:
- Reset: state IDLE; mod_type=000, mod_dout=0, busy=0, tx_active=0, done=0; pause counters cleared. Buffer contents are not reset.
- rx_field is registered once as rx_q. A pause is valid when rx_q stays low for at least PAUSE_MIN consecutive cycles; the low-run counter saturates. Shorter lows are ignored.
- Edge cycle E is the cycle in which rx_q first reads 1 after a valid pause.
- Buffer writes:
  - take effect when wr_en=1 and busy=0;
  - are ignored while busy=1.
- States:
  - IDLE: on start, latch fdt = max(fdt_cycles, MIN_FDT) and latch nbits, then go to ARMED.
  - ARMED: wait for the first edge E. At E, clear the delay counter and go to WAIT. Stays in ARMED indefinitely if no pause arrives.
  - WAIT: delay counter increments every cycle. A new edge E resets it to 0 (the reader frame is continuing). When the counter reaches fdt-1, the next cycle is TX, so the first TX cycle is E+fdt.
  - TX:
    - Sends a start-of-frame bit (logic 1), then nbits data bits: byte 0 first, LSB first within a byte, bit index k = byte k>>3, bit k&7.
    - Each bit lasts BIT_CYCLES cycles. mod_dout = bit for the first BIT_CYCLES/2 cycles and ~bit for the second half.
    - mod_type = MOD_TX for the entire TX state.
    - After the last data bit, one end-of-frame period with mod_dout=0 for BIT_CYCLES cycles.
    - Then the next cycle enters IDLE with mod_type=000 and done=1 for exactly that one cycle.
  - nbits=0: TX sends SOF plus EOF only.
- rx_field is ignored during TX.
- Abort: any state goes to IDLE on the next edge with mod_type=000 and mod_dout=0; no done pulse. Simultaneous start and abort: abort wins.
- start while busy=1 is ignored.
- rst during TX behaves like abort, and outputs take their reset values on that edge.
- Counter widths:
  - delay counter: 12 bits;
  - bit counter: 9 bits, covering SOF + 255 bits + EOF;
  - cycle-in-bit counter: log2(BIT_CYCLES) bits, wrapping at BIT_CYCLES-1.

Decomposition:
- Package hi_sim_seq_pkg holds:
  - the state enum (IDLE, ARMED, WAIT, TX);
  - MOD_LISTEN=3'b000 and default MOD_TX;
  - PAUSE_MIN, MIN_FDT and BIT_CYCLES defaults.
- Sub-module hi_sim_manchester_tx holds the bit/half-bit timing, SOF/EOF framing and buffer read addressing. It takes a go input and returns a last-cycle indication to the parent FSM.

Test Plan:
- Load byte0=0xA5, nbits=8, fdt_cycles=1172, start. Drive rx_field low 20 cycles, then high (edge at E).
  - mod_type=100 from E+1172.
  - mod_dout sequence per half-bit: SOF 1,0; then bits 1,0,1,0,0,1 ...
  - Total TX = 10 x 128 cycles; done pulse at E+1172+1280; mod_type back to 000.
- Three pauses 200 cycles apart, then quiet with fdt=1172.
  - TX starts exactly 1172 cycles after the third edge.
  - No TX starts after the first or second edge.
- Glitch: rx_field low for 5 cycles only.
  - Sequencer stays ARMED; no TX.
- fdt_cycles=100.
  - Clamped: TX begins at E+256.
- Abort asserted 300 cycles into TX.
  - Next cycle: mod_type=000, mod_dout=0, busy=0, no done.
  - New start then works normally.
- Writes while busy are dropped.
  - Write 0xFF to addr 0 during WAIT; the transmitted byte is still the pre-start value.
  - nbits=0 produces SOF then EOF: 256 cycles of TX.

Source files
------------

// File: rtl/hi_sim_seq_pkg.sv
// Shared types and defaults for the 13.56 MHz tag-simulation response sequencer.
package hi_sim_seq_pkg;

    // Sequencer states: listen, wait for reader frame end, count FDT, transmit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WAIT  = 2'd2,
        TX    = 2'd3
    } state_e;

    // Modulator selections.
    localparam logic [2:0] MOD_LISTEN         = 3'b000;
    localparam logic [2:0] MOD_TX_DEFAULT     = 3'b100;

    // Timing defaults (carrier cycles).
    localparam int         BIT_CYCLES_DEFAULT = 128;
    localparam int         PAUSE_MIN_DEFAULT  = 8;
    localparam int         MIN_FDT_DEFAULT    = 256;

    // Field widths.
    localparam int         FDT_W      = 12;
    localparam int         NBITS_W    = 8;
    localparam int         BUF_AW     = 5;
    localparam int         BUF_DEPTH  = 32;
    localparam int         BITCNT_W   = 9;   // SOF + 255 data bits + EOF

    // Lower clamp on the requested frame delay.
    function automatic logic [FDT_W-1:0] clamp_fdt(input logic [FDT_W-1:0] req,
                                                   input logic [FDT_W-1:0] floor_v);
        return (req < floor_v) ? floor_v : req;
    endfunction

endpackage

// File: rtl/hi_sim_seq_if.sv
// Control, response-buffer and modulator signals of the response sequencer.
interface hi_sim_seq_if;
    import hi_sim_seq_pkg::*;

    logic               start;
    logic               abort;
    logic [FDT_W-1:0]   fdt_cycles;
    logic [NBITS_W-1:0] nbits;
    logic               wr_en;
    logic [BUF_AW-1:0]  wr_addr;
    logic [7:0]         wr_data;
    logic               rx_field;
    logic [2:0]         mod_type;
    logic               mod_dout;
    logic               busy;
    logic               tx_active;
    logic               done;

    // ARM / field side driving the sequencer.
    modport master (
        output start, abort, fdt_cycles, nbits, wr_en, wr_addr, wr_data, rx_field,
        input  mod_type, mod_dout, busy, tx_active, done
    );

    // The sequencer itself.
    modport slave (
        input  start, abort, fdt_cycles, nbits, wr_en, wr_addr, wr_data, rx_field,
        output mod_type, mod_dout, busy, tx_active, done
    );

endinterface

// File: rtl/hi_sim_manchester_tx.sv
// Manchester framer: SOF, data bits from the response buffer (byte 0 first,
// LSB first), EOF; flags the final cycle of the frame to the parent FSM.
module hi_sim_manchester_tx
    import hi_sim_seq_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_DEFAULT
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               go_i,       // high for the whole TX state
    input  logic [NBITS_W-1:0] nbits_i,
    input  logic [7:0]         rd_data_i,
    output logic [BUF_AW-1:0]  rd_addr_o,
    output logic               dout_o,
    output logic               last_o
);

    localparam int              CYC_W    = $clog2(BIT_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(BIT_CYCLES / 2);

    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [BITCNT_W-1:0] bit_q, bit_d;
    logic [BITCNT_W-1:0] eof_idx;
    logic [NBITS_W-1:0]  data_idx;
    logic                is_sof;
    logic                is_eof;
    logic                sym;

    // Bit slot 0 is SOF, slots 1..nbits are data, slot nbits+1 is EOF.
    assign eof_idx   = {1'b0, nbits_i} + BITCNT_W'(1);
    assign data_idx  = NBITS_W'(bit_q - BITCNT_W'(1));
    assign rd_addr_o = data_idx[7:3];
    assign is_sof    = (bit_q == '0);
    assign is_eof    = (bit_q == eof_idx);
    assign sym       = is_sof ? 1'b1 : rd_data_i[data_idx[2:0]];
    assign last_o    = go_i && is_eof && (cyc_q == CYC_LAST);

    // Manchester symbol: bit in the first half, inverted in the second; EOF idles low.
    always_comb begin
        dout_o = 1'b0;
        if (go_i && !is_eof) begin
            dout_o = (cyc_q < CYC_HALF) ? sym : ~sym;
        end
    end

    // Cycle-in-bit and bit-slot counters run only while transmitting.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cyc_d = '0;
        bit_d = '0;
        if (go_i) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                bit_d = bit_q + BITCNT_W'(1);
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
                bit_d = bit_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cyc_q <= '0;
            bit_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/hi_sim_seq.sv
// Response sequencer: detects end of a reader frame on rx_field, waits the
// programmed frame delay, then transmits the buffered Manchester response.
module hi_sim_seq
    import hi_sim_seq_pkg::*;
#(
    parameter int         BIT_CYCLES = BIT_CYCLES_DEFAULT,
    parameter int         PAUSE_MIN  = PAUSE_MIN_DEFAULT,
    parameter int         MIN_FDT    = MIN_FDT_DEFAULT,
    parameter logic [2:0] MOD_TX     = MOD_TX_DEFAULT
)(
    input  logic        ck_1356meg,
    input  logic        rst,
    hi_sim_seq_if.slave bus
);

    localparam int               LOW_W     = $clog2(PAUSE_MIN + 1);
    localparam logic [LOW_W-1:0] LOW_SAT   = LOW_W'(PAUSE_MIN);
    localparam logic [FDT_W-1:0] MIN_FDT_V = FDT_W'(MIN_FDT);

    state_e             state_q, state_d;
    logic [FDT_W-1:0]   fdt_q, fdt_d;
    logic [NBITS_W-1:0] nbits_q, nbits_d;
    logic [FDT_W-1:0]   dly_q, dly_d;
    logic               done_q, done_d;

    logic               rx_q;
    logic [LOW_W-1:0]   low_cnt_q, low_cnt_d;
    logic               frame_end;

    logic               busy;
    logic               tx_active;
    logic [7:0]         resp_mem [BUF_DEPTH];
    logic [BUF_AW-1:0]  rd_addr;
    logic [7:0]         rd_byte;
    logic               tx_dout;
    logic               tx_last;

    // Saturating count of consecutive low cycles of the registered field.
    always_comb begin
        low_cnt_d = low_cnt_q;
        if (rx_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_SAT) begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end
    end

    // First high cycle after a pause of at least PAUSE_MIN cycles.
    assign frame_end = rx_q && (low_cnt_q == LOW_SAT);

    // Field register and pause counter.
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            rx_q      <= 1'b1;
            low_cnt_q <= '0;
        end else begin
            rx_q      <= bus.rx_field;
            low_cnt_q <= low_cnt_d;
        end
    end

    // Response buffer: ARM writes land only while the sequencer is idle.
    always_ff @(posedge ck_1356meg) begin
        // NOTE: the buffer has no reset; its contents are whatever ARM last loaded.
        if (bus.wr_en && !busy) begin
            resp_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign rd_byte = resp_mem[rd_addr];

    // Next-state logic; abort overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        fdt_d   = fdt_q;
        nbits_d = nbits_q;
        dly_d   = dly_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        fdt_d   = clamp_fdt(bus.fdt_cycles, MIN_FDT_V);
                        nbits_d = bus.nbits;
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    // The edge cycle itself counts as delay 0, so WAIT starts at 1.
                    if (frame_end) begin
                        dly_d   = FDT_W'(1);
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (frame_end) begin
                        dly_d = FDT_W'(1);
                    end else if (dly_q == fdt_q - FDT_W'(1)) begin
                        state_d = TX;
                    end else begin
                        dly_d = dly_q + FDT_W'(1);
                    end
                end
                TX: begin
                    if (tx_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            state_q <= IDLE;
            fdt_q   <= '0;
            nbits_q <= '0;
            dly_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fdt_q   <= fdt_d;
            nbits_q <= nbits_d;
            dly_q   <= dly_d;
            done_q  <= done_d;
        end
    end

    hi_sim_manchester_tx #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_tx (
        .clk       (ck_1356meg),
        .rst       (rst),
        .go_i      (tx_active),
        .nbits_i   (nbits_q),
        .rd_data_i (rd_byte),
        .rd_addr_o (rd_addr),
        .dout_o    (tx_dout),
        .last_o    (tx_last)
    );

    assign busy          = (state_q != IDLE);
    assign tx_active     = (state_q == TX);
    assign bus.busy      = busy;
    assign bus.tx_active = tx_active;
    assign bus.mod_type  = tx_active ? MOD_TX : MOD_LISTEN;
    assign bus.mod_dout  = tx_active & tx_dout;
    assign bus.done      = done_q;

endmodule
